// File: rtl/axis_frame_tx_pkg.sv
// Shared definitions for axis_frame_tx: AHB register map, CTRL bit positions and
// the stream-side FSM state encoding.
package axis_frame_tx_pkg;

  localparam logic [15:0] CtrlOffset   = 16'h0000;
  localparam logic [15:0] StatusOffset = 16'h0004;
  localparam logic [15:0] LenOffset    = 16'h0008;
  localparam logic [15:0] BufBase      = 16'h1000;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlContBit  = 1;
  localparam int unsigned CtrlStopBit  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream
  } state_e;

  // Byte offset into the sample buffer window; callers check the upper bits for a hit.
  function automatic logic [15:0] buf_offset(logic [15:0] addr);
    return addr - BufBase;
  endfunction

endpackage

// File: rtl/axis_frame_tx_if.sv
// Bundle of the AXI-Stream master and AHB-Lite slave signals of axis_frame_tx.
// The master modport is the transmitter's view; slave is the environment's view.
interface axis_frame_tx_if #(
  parameter int unsigned DW = 16
);

  logic [DW-1:0] tdata_m;
  logic          tuser_m;
  logic          tlast_m;
  logic          tvalid_m;
  logic          tready_m;

  logic [31:0]   haddr_s;
  logic [2:0]    hburst_s;
  logic [2:0]    hsize_s;
  logic [1:0]    htrans_s;
  logic [31:0]   hwdata_s;
  logic          hwrite_s;
  logic          hsel_s;
  logic [31:0]   hrdata_s;
  logic          hreadyout_s;
  logic          hresp_s;

  modport master (
    output tdata_m, tuser_m, tlast_m, tvalid_m,
    input  tready_m,
    input  haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    output hrdata_s, hreadyout_s, hresp_s
  );

  modport slave (
    input  tdata_m, tuser_m, tlast_m, tvalid_m,
    output tready_m,
    output haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    input  hrdata_s, hreadyout_s, hresp_s
  );

endinterface

// File: rtl/axis_frame_tx_ram.sv
// True dual-port sample buffer: port A read/write, port B read-only with enable.
// Both ports have one cycle of read latency and return the pre-write contents.
module axis_frame_tx_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [DW-1:0] wdata_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic          en_b_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_a_i) begin
      mem_q[addr_a_i] <= wdata_a_i;
    end
    rdata_a_o <= mem_q[addr_a_i];
  end

  // Port B holds its last word while disabled so a stalled prefetch stays valid.
  always_ff @(posedge clk_i) begin
    if (en_b_i) begin
      rdata_b_o <= mem_q[addr_b_i];
    end
  end

endmodule

// File: rtl/axis_frame_tx.sv
// AHB-writable sample buffer streamed out as framed AXI-Stream (tuser first, tlast last).
// Define AXIS_FRAME_TX_RDBACK_EN to make the buffer window readable over AHB.
module axis_frame_tx
  import axis_frame_tx_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input logic            clk,
  input logic            reset,
  input logic            ce,
  axis_frame_tx_if.master bus
);

  localparam int unsigned BufSpanLsb = AW + 2;

  // Stream side state
  state_e        state_q, state_d;
  logic [AW-1:0] len_q;
  logic [AW-1:0] frame_len_q, frame_len_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] beat_q, beat_d;
  logic          primed_q, primed_d;
  logic          cont_q, cont_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tuser_q, tuser_d;
  logic          tlast_q, tlast_d;
  logic          hs, load, busy;

  // AHB side
  logic          addr_phase, rd_en;
  logic [15:0]   a_addr, a_off;
  logic          a_buf_hit;
  logic [AW-1:0] a_buf_idx;
  logic          wr_ctrl_q, wr_len_q, wr_buf_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   reg_rdata, hrdata_q;
  logic          start_pulse;

  // RAM ports
  logic          ram_en_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_rdata_a, ram_rdata_b;

  assign addr_phase = bus.hsel_s & bus.htrans_s[1];
  assign rd_en      = addr_phase & ~bus.hwrite_s;
  assign a_addr     = bus.haddr_s[15:0];
  assign a_off      = buf_offset(a_addr);
  assign a_buf_hit  = (a_addr >= BufBase) && (a_off[15:BufSpanLsb] == '0);
  assign a_buf_idx  = a_off[AW+1:2];

  assign busy = (state_q != StIdle);

  always_comb begin
    reg_rdata = '0;
    case (a_addr)
      CtrlOffset:   reg_rdata[CtrlContBit] = cont_q;
      StatusOffset: reg_rdata = {frame_cnt_q, 15'd0, busy};
      LenOffset:    reg_rdata[AW-1:0] = len_q;
      default:      reg_rdata = '0;
    endcase
  end

  // Address-phase decode captured for the write data phase and the read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ctrl_q <= 1'b0;
      wr_len_q  <= 1'b0;
      wr_buf_q  <= 1'b0;
      widx_q    <= '0;
      hrdata_q  <= '0;
    end else begin
      wr_ctrl_q <= addr_phase & bus.hwrite_s & (a_addr == CtrlOffset);
      wr_len_q  <= addr_phase & bus.hwrite_s & (a_addr == LenOffset);
      wr_buf_q  <= addr_phase & bus.hwrite_s & a_buf_hit;
      widx_q    <= a_buf_idx;
      hrdata_q  <= rd_en ? reg_rdata : '0;
    end
  end

  assign start_pulse = wr_ctrl_q & bus.hwdata_s[CtrlStartBit];

  always_comb begin
    cont_d = cont_q;
    if (wr_ctrl_q) begin
      cont_d = bus.hwdata_s[CtrlContBit] & ~bus.hwdata_s[CtrlStopBit];
    end
  end

  // Port A is shared: a write data phase takes priority over a read address phase, so a
  // buffer read issued directly behind a buffer write needs one idle cycle in between.
  assign ram_addr_a = wr_buf_q ? widx_q : a_buf_idx;

  axis_frame_tx_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i     (clk),
    .we_a_i    (wr_buf_q),
    .addr_a_i  (ram_addr_a),
    .wdata_a_i (bus.hwdata_s[DW-1:0]),
    .rdata_a_o (ram_rdata_a),
    .en_b_i    (ram_en_b),
    .addr_b_i  (ram_addr_b),
    .rdata_b_o (ram_rdata_b)
  );

`ifdef AXIS_FRAME_TX_RDBACK_EN
  logic buf_rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_rd_q <= 1'b0;
    end else begin
      buf_rd_q <= rd_en & a_buf_hit;
    end
  end

  assign bus.hrdata_s = buf_rd_q ? 32'(ram_rdata_a) : hrdata_q;
`else
  logic unused_rdata_a;
  assign unused_rdata_a = ^ram_rdata_a;
  assign bus.hrdata_s   = hrdata_q;
`endif

  assign bus.hreadyout_s = 1'b1;
  assign bus.hresp_s     = 1'b0;

  assign hs = tvalid_q & bus.tready_m;

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    primed_d    = primed_q;
    frame_cnt_d = frame_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    ram_en_b    = 1'b0;
    ram_addr_b  = ptr_q;
    load        = 1'b0;

    if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_d     = StFetch;
            frame_len_d = len_q;
            ptr_d       = '0;
            beat_d      = '0;
            primed_d    = 1'b0;
          end
        end
        StFetch: begin
          // A primed fetch already read word 0 during the last beat of the previous frame.
          ram_en_b = 1'b1;
          ptr_d    = ptr_q + AW'(1);
          load     = primed_q;
          primed_d = 1'b0;
          state_d  = StStream;
        end
        StStream: begin
          if (hs && tlast_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            tvalid_d    = 1'b0;
            tuser_d     = 1'b0;
            tlast_d     = 1'b0;
            if (cont_q) begin
              state_d     = StFetch;
              frame_len_d = len_q;
              beat_d      = '0;
              ram_en_b    = 1'b1;
              ram_addr_b  = '0;
              ptr_d       = AW'(1);
              primed_d    = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else if (!tvalid_q || hs) begin
            load     = 1'b1;
            ram_en_b = 1'b1;
            ptr_d    = ptr_q + AW'(1);
          end
        end
        default: state_d = StIdle;
      endcase

      if (load) begin
        tdata_d  = ram_rdata_b;
        tvalid_d = 1'b1;
        tuser_d  = (beat_q == '0);
        tlast_d  = (beat_q == frame_len_q);
        beat_d   = beat_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      cont_q      <= 1'b0;
      frame_len_q <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      primed_q    <= 1'b0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      if (wr_len_q) begin
        len_q <= bus.hwdata_s[AW-1:0];
      end
      cont_q      <= cont_d;
      frame_len_q <= frame_len_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      primed_q    <= primed_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign bus.tdata_m  = tdata_q;
  assign bus.tvalid_m = tvalid_q;
  assign bus.tuser_m  = tuser_q;
  assign bus.tlast_m  = tlast_q;

  logic unused_ahb;
  assign unused_ahb = ^{bus.haddr_s[31:16], bus.hburst_s, bus.hsize_s, bus.htrans_s[0],
                        bus.hwdata_s, a_off[1:0]};

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed self-checking bench for axis_frame_tx: framing, stalls, continuous mode,
// clock enable, reset and buffer readback.
module tb_axis_frame_tx;
  import axis_frame_tx_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  int   n_checks = 0;
  int   n_fail   = 0;

  axis_frame_tx_if #(.DW(DW)) bus ();

  axis_frame_tx #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW+2:0] obs();
    return {bus.tvalid_m, bus.tuser_m, bus.tlast_m, bus.tdata_m};
  endfunction

  function automatic logic [DW+2:0] beat_vec(input logic v, input logic u, input logic l,
                                             input logic [DW-1:0] d);
    return {v, u, l, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ahb_idle();
    bus.hsel_s   = 1'b0;
    bus.htrans_s = 2'b00;
    bus.hwrite_s = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.hsel_s   = 1'b1;
    bus.htrans_s = 2'b10;
    bus.hwrite_s = 1'b1;
    bus.haddr_s  = addr;
    tick();
    ahb_idle();
    bus.hwdata_s = data;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.hsel_s   = 1'b1;
    bus.htrans_s = 2'b10;
    bus.hwrite_s = 1'b0;
    bus.haddr_s  = addr;
    tick();
    ahb_idle();
    data = bus.hrdata_s;
    tick();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ce           = 1'b1;
    bus.tready_m = 1'b1;
    ahb_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_stream: got %h expected 0", obs());
    end
    n_checks++;
    if ({bus.hrdata_s, bus.hreadyout_s, bus.hresp_s} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ahb_out: got %h/%b/%b expected 0/1/0",
               bus.hrdata_s, bus.hreadyout_s, bus.hresp_s);
    end
    reset = 1'b0;
    ahb_read(32'(CtrlOffset), rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", rd); end
    ahb_read(32'(LenOffset), rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_len: got %h expected 0", rd); end
  endtask

  task automatic test_ramp();
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 8; i++) ahb_write(32'h1000 + 32'(4 * i), 32'(i));
    ahb_write(32'(LenOffset), 32'd7);
    ahb_read(32'(LenOffset), rd);
    n_checks++;
    if (rd !== 32'd7) begin n_fail++; $display("FAIL ramp_len_rd: got %h expected 7", rd); end
    ahb_write(32'(CtrlOffset), 32'h1);
    // Now one step past edge E: FETCH, then STREAM, beat 0 only after E+2.
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.tvalid_m !== 1'b0) begin
        n_fail++;
        $display("FAIL ramp_latency: cycle %0d tvalid %b expected 0", i, bus.tvalid_m);
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs() !== beat_vec(1'b1, k == 0, k == 7, DW'(k))) begin
        n_fail++;
        $display("FAIL ramp_beat%0d: got %h expected %h", k, obs(),
                 beat_vec(1'b1, k == 0, k == 7, DW'(k)));
      end
      tick();
    end
    n_checks++;
    if (bus.tvalid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_end: tvalid %b expected 0", bus.tvalid_m);
    end
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL ramp_status: got %h expected 00010000", rd);
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    int          k;
    logic        started;
    do_reset();
    ahb_write(32'(LenOffset), 32'd7);
    ahb_write(32'(CtrlOffset), 32'h1);
    k       = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 64 && k < 8; cyc++) begin
      if (started || bus.tvalid_m) begin
        started = 1'b1;
        n_checks++;
        if (obs() !== beat_vec(1'b1, k == 0, k == 7, DW'(k))) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h expected %h", k, obs(),
                   beat_vec(1'b1, k == 0, k == 7, DW'(k)));
        end
        if (bus.tvalid_m && bus.tready_m) k++;
      end
      tick();
      bus.tready_m = ~bus.tready_m;
    end
    n_checks++;
    if (k != 8) begin n_fail++; $display("FAIL stall_count: got %0d beats expected 8", k); end
    n_checks++;
    if (bus.tvalid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: tvalid %b expected 0", bus.tvalid_m);
    end
    bus.tready_m = 1'b1;
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL stall_status: got %h expected 00010000", rd);
    end
  endtask

  task automatic test_cont();
    logic [31:0] rd;
    int          pos;
    do_reset();
    ahb_write(32'(LenOffset), 32'd3);
    ahb_write(32'(CtrlOffset), 32'h3);
    tick();
    tick();
    // Three 4-beat frames with one gap cycle each; STOP lands during frame 3.
    for (int i = 0; i < 14; i++) begin
      pos = i % 5;
      n_checks++;
      if (pos == 4) begin
        if (bus.tvalid_m !== 1'b0) begin
          n_fail++;
          $display("FAIL cont_gap%0d: tvalid %b expected 0", i, bus.tvalid_m);
        end
      end else if (obs() !== beat_vec(1'b1, pos == 0, pos == 3, DW'(pos))) begin
        n_fail++;
        $display("FAIL cont_beat%0d: got %h expected %h", i, obs(),
                 beat_vec(1'b1, pos == 0, pos == 3, DW'(pos)));
      end
      if (i == 11) begin
        bus.hsel_s   = 1'b1;
        bus.htrans_s = 2'b10;
        bus.hwrite_s = 1'b1;
        bus.haddr_s  = 32'(CtrlOffset);
      end else if (i == 12) begin
        ahb_idle();
        bus.hwdata_s = 32'h4;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.tvalid_m !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_stopped%0d: tvalid %b expected 0", i, bus.tvalid_m);
      end
      tick();
    end
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0003_0000) begin
      n_fail++;
      $display("FAIL cont_status: got %h expected 00030000", rd);
    end
  endtask

  task automatic test_ce_reset();
    logic [31:0] rd;
    do_reset();
    ahb_write(32'(LenOffset), 32'd7);
    ahb_write(32'(CtrlOffset), 32'h1);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs() !== beat_vec(1'b1, k == 0, 1'b0, DW'(k))) begin
        n_fail++;
        $display("FAIL ce_pre%0d: got %h expected %h", k, obs(),
                 beat_vec(1'b1, k == 0, 1'b0, DW'(k)));
      end
      if (k < 2) tick();
    end
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs() !== beat_vec(1'b1, 1'b0, 1'b0, DW'(2))) begin
        n_fail++;
        $display("FAIL ce_frozen%0d: got %h expected %h", i, obs(),
                 beat_vec(1'b1, 1'b0, 1'b0, DW'(2)));
      end
    end
    ce = 1'b1;
    tick();
    n_checks++;
    if (obs() !== beat_vec(1'b1, 1'b0, 1'b0, DW'(3))) begin
      n_fail++;
      $display("FAIL ce_resume: got %h expected %h", obs(), beat_vec(1'b1, 1'b0, 1'b0, DW'(3)));
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({obs(), bus.hrdata_s} !== '0) begin
      n_fail++;
      $display("FAIL midreset_out: got %h/%h expected 0", obs(), bus.hrdata_s);
    end
    reset = 1'b0;
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL midreset_status: got %h expected 0", rd); end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    do_reset();
    ahb_write(32'(BufBase), 32'h0000_ABCD);
    ahb_write(32'(LenOffset), 32'd0);
    ahb_write(32'(CtrlOffset), 32'h1);
    tick();
    tick();
    n_checks++;
    if (obs() !== beat_vec(1'b1, 1'b1, 1'b1, 16'hABCD)) begin
      n_fail++;
      $display("FAIL single_beat: got %h expected %h", obs(),
               beat_vec(1'b1, 1'b1, 1'b1, 16'hABCD));
    end
    tick();
    n_checks++;
    if (bus.tvalid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: tvalid %b expected 0", bus.tvalid_m);
    end
    ahb_read(32'(StatusOffset), rd);
    n_checks++;
    if (rd !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL single_status: got %h expected 00010000", rd);
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    logic [31:0] exp_rd;
`ifdef AXIS_FRAME_TX_RDBACK_EN
    exp_rd = 32'h0000_1234;
`else
    exp_rd = 32'h0;
`endif
    do_reset();
    ahb_write(32'h0000_1014, 32'hDEAD_1234);
    ahb_read(32'h0000_1014, rd);
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL readback_word5: got %h expected %h", rd, exp_rd);
    end
    ahb_read(32'h0000_0100, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h expected 0", rd); end
    ahb_read(32'h0000_2000, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL past_buf_rd: got %h expected 0", rd); end
  endtask

  initial begin
    reset        = 1'b1;
    ce           = 1'b1;
    bus.tready_m = 1'b1;
    bus.haddr_s  = '0;
    bus.hburst_s = 3'b000;
    bus.hsize_s  = 3'b010;
    bus.hwdata_s = '0;
    ahb_idle();
    test_reset();
    test_ramp();
    test_stall();
    test_cont();
    test_ce_reset();
    test_single();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
